// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, trap cause codes
// and the LSU state type.
package rv32_pkg;

    // funct3 size/sign encodings for loads (stores use the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // mcause exception codes raised by the LSU
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_RESP,
        LSU_EXC
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Single-outstanding req/ready data-memory bus between the LSU and memory.
interface mem_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for a
// request, alignment/funct3 legality check, and lane select plus
// sign/zero extension of returned load words.
module lsu_align
    import rv32_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    output logic [3:0]  cause,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_ext
);

    // Request side: lanes, store replication and fault classification
    always_comb begin
        be    = '0;
        wdata = '0;
        fault = 1'b0;
        cause = '0;
        if (is_store) begin
            case (req_funct3)
                F3_B: begin
                    be    = 4'b0001 << req_off;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    if (req_off[0]) begin
                        fault = 1'b1;
                        cause = CAUSE_ST_MISALIGN;
                    end else begin
                        be    = 4'b0011 << {req_off[1], 1'b0};
                        wdata = {2{store_data[15:0]}};
                    end
                end
                F3_W: begin
                    if (req_off != 2'b00) begin
                        fault = 1'b1;
                        cause = CAUSE_ST_MISALIGN;
                    end else begin
                        be    = 4'hF;
                        wdata = store_data;
                    end
                end
                default: begin
                    fault = 1'b1;
                    cause = CAUSE_ILLEGAL;
                end
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_BU: be = 4'b0001 << req_off;
                F3_H, F3_HU: begin
                    if (req_off[0]) begin
                        fault = 1'b1;
                        cause = CAUSE_LD_MISALIGN;
                    end else begin
                        be = 4'b0011 << {req_off[1], 1'b0};
                    end
                end
                F3_W: begin
                    if (req_off != 2'b00) begin
                        fault = 1'b1;
                        cause = CAUSE_LD_MISALIGN;
                    end else begin
                        be = 4'hF;
                    end
                end
                default: begin
                    fault = 1'b1;
                    cause = CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Response side: pick the addressed lane and extend to 32 bits
    always_comb begin
        lane_b   = '0;
        lane_h   = '0;
        load_ext = rdata;
        case (rsp_off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = rsp_off[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_funct3)
            F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_ext = {24'h0, lane_b};
            F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_ext = {16'h0, lane_h};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one data-memory transfer at a time,
// stalls the pipeline while it is in flight, returns extended load data
// and raises misalign/illegal/timeout traps towards the CSR unit.
module mem_lsu
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    input  logic        lsu_flush,
    mem_lsu_if.master   dmem,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_stall,
    output logic [3:0]  cause_out,
    output logic        cause_set,
    output logic        mepc_set,
    output logic [29:0] exc_addr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             flushed_q;

    logic             op_presented;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic             req_fault;
    logic [3:0]       req_cause;
    logic [31:0]      load_ext;

    // pc is word-aligned for trap reporting; its low bits carry no information
    logic unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, pc[1:0]};

    assign op_presented = (mem_read | mem_write) && !lsu_flush;

    lsu_align u_align (
        .is_store   (mem_write),
        .req_funct3 (funct3),
        .req_off    (addr[1:0]),
        .store_data (store_data),
        .be         (req_be),
        .wdata      (req_wdata),
        .fault      (req_fault),
        .cause      (req_cause),
        .rsp_funct3 (f3_q),
        .rsp_off    (off_q),
        .rdata      (dmem.rdata),
        .load_ext   (load_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    // Next-state decode plus combinational stall and one-cycle pulses
    always_comb begin
        state_next = state;
        lsu_stall  = 1'b0;
        load_valid = 1'b0;
        cause_set  = 1'b0;
        mepc_set   = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (op_presented) begin
                    lsu_stall  = 1'b1;
                    state_next = req_fault ? LSU_EXC : LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                lsu_stall = 1'b1;
                if (dmem.ready) begin
                    state_next = LSU_RESP;
                end else if (cnt == CNT_LAST) begin
                    // a killed op that times out is dropped silently
                    state_next = (flushed_q || lsu_flush) ? LSU_IDLE : LSU_EXC;
                end
            end
            LSU_RESP: begin
                load_valid = !dmem.we && !flushed_q && !lsu_flush;
                state_next = LSU_IDLE;
            end
            LSU_EXC: begin
                cause_set  = !lsu_flush;
                mepc_set   = !lsu_flush;
                state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    // Bus outputs, response data, trap info and the timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.be    <= '0;
            dmem.wdata <= '0;
            load_data  <= '0;
            cause_out  <= '0;
            exc_addr   <= '0;
            cnt        <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            flushed_q  <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (op_presented) begin
                        exc_addr  <= pc[31:2];
                        flushed_q <= 1'b0;
                        cnt       <= '0;
                        if (req_fault) begin
                            cause_out <= req_cause;
                        end else begin
                            dmem.req   <= 1'b1;
                            dmem.we    <= mem_write;
                            dmem.addr  <= {addr[31:2], 2'b00};
                            dmem.be    <= req_be;
                            dmem.wdata <= req_wdata;
                            f3_q       <= funct3;
                            off_q      <= addr[1:0];
                        end
                    end
                end
                LSU_BUSY: begin
                    if (lsu_flush) flushed_q <= 1'b1;
                    if (dmem.ready) begin
                        dmem.req  <= 1'b0;
                        load_data <= load_ext;
                        cnt       <= '0;
                    end else if (cnt == CNT_LAST) begin
                        dmem.req  <= 1'b0;
                        cause_out <= dmem.we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: ops are driven one at a time by a
// driver task, expected bus/load/trap events are queued when an op is
// driven and popped by a negedge monitor when the DUT produces them.
module tb_mem_lsu;

    localparam int TB_TIMEOUT = 6;

    typedef enum logic [1:0] { EV_BUS, EV_LOAD, EV_TRAP } ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [3:0]  cause;
        logic [29:0] exc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, lsu_flush;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, pc;
    logic [31:0] load_data;
    logic        load_valid, lsu_stall, cause_set, mepc_set;
    logic [3:0]  cause_out;
    logic [29:0] exc_addr;

    int checks = 0;
    int errors = 0;
    int lv_seen = 0;
    int trap_seen = 0;
    ev_t sb[$];
    ev_t mon_e;
    bit  mon_ok;

    mem_lsu_if dmem();

    mem_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .pc         (pc),
        .lsu_flush  (lsu_flush),
        .dmem       (dmem),
        .load_data  (load_data),
        .load_valid (load_valid),
        .lsu_stall  (lsu_stall),
        .cause_out  (cause_out),
        .cause_set  (cause_set),
        .mepc_set   (mepc_set),
        .exc_addr   (exc_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        ev_t e;
        e = '{kind: EV_BUS, we: we, addr: a, be: be, data: wd, cause: 4'h0, exc: 30'h0};
        sb.push_back(e);
    endtask

    task automatic sb_load(input logic [31:0] d);
        ev_t e;
        e = '{kind: EV_LOAD, we: 1'b0, addr: 32'h0, be: 4'h0, data: d, cause: 4'h0, exc: 30'h0};
        sb.push_back(e);
    endtask

    task automatic sb_trap(input logic [3:0] c, input logic [29:0] x);
        ev_t e;
        e = '{kind: EV_TRAP, we: 1'b0, addr: 32'h0, be: 4'h0, data: 32'h0, cause: c, exc: x};
        sb.push_back(e);
    endtask

    task automatic sb_pop(input ev_kind_e k, output ev_t e, output bit ok);
        ok = 1'b0;
        check("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_kind", 32'(e.kind), 32'(k));
            ok = (e.kind == k);
        end
    endtask

    // Scoreboard monitor: every DUT-produced event must match the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem.req && dmem.ready) begin
                sb_pop(EV_BUS, mon_e, mon_ok);
                if (mon_ok) begin
                    check("bus_we", dmem.we, mon_e.we);
                    check("bus_addr", dmem.addr, mon_e.addr);
                    if (mon_e.we) begin
                        check("bus_be", dmem.be, mon_e.be);
                        check("bus_wdata", dmem.wdata, mon_e.data);
                    end
                end
            end
            if (load_valid) begin
                lv_seen++;
                sb_pop(EV_LOAD, mon_e, mon_ok);
                if (mon_ok) check("load_data", load_data, mon_e.data);
            end
            if (cause_set || mepc_set) begin
                trap_seen++;
                check("mepc_with_cause", mepc_set, cause_set);
                sb_pop(EV_TRAP, mon_e, mon_ok);
                if (mon_ok) begin
                    check("cause_out", cause_out, mon_e.cause);
                    check("exc_addr", exc_addr, mon_e.exc);
                end
            end
        end
    end

    // Drive one op, answer the bus after 'delay' unready BUSY cycles,
    // optionally flush at loop cycle 'flush_at', then check per-op totals.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] p,
                         input logic [31:0] rdata, input int delay, input int flush_at,
                         input int exp_stall, input int exp_lv, input int exp_trap,
                         input logic exp_req);
        int          stall_cyc = 0;
        int          bus_cyc = 0;
        int          lv0 = lv_seen;
        int          tr0 = trap_seen;
        bit          done = 1'b0;
        bit          req_seen = 1'b0;
        bit          unstable = 1'b0;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        logic        s_we;
        mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; pc = p;
        for (int cyc = 0; cyc < TB_TIMEOUT + 10 && !done; cyc++) begin
            lsu_flush = (cyc == flush_at);
            if (dmem.req) begin
                dmem.ready = (bus_cyc == delay);
                dmem.rdata = dmem.ready ? rdata : 32'h0;
                bus_cyc++;
            end else begin
                dmem.ready = 1'b0;
                dmem.rdata = 32'h0;
            end
            @(negedge clk);
            if (lsu_stall) stall_cyc++;
            else done = 1'b1;
            if (dmem.req) begin
                if (!req_seen) begin
                    s_addr = dmem.addr; s_wdata = dmem.wdata; s_be = dmem.be; s_we = dmem.we;
                    req_seen = 1'b1;
                end else if (s_addr !== dmem.addr || s_wdata !== dmem.wdata ||
                             s_be !== dmem.be || s_we !== dmem.we) begin
                    unstable = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        check("op_budget", 32'(done), 32'd1);
        mem_read = 1'b0; mem_write = 1'b0; lsu_flush = 1'b0;
        dmem.ready = 1'b0; dmem.rdata = 32'h0;
        check("stall_cycles", stall_cyc, exp_stall);
        check("load_valid_count", lv_seen - lv0, exp_lv);
        check("trap_count", trap_seen - tr0, exp_trap);
        check("req_seen", 32'(req_seen), 32'(exp_req));
        if (req_seen) check("bus_stable", 32'(unstable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; lsu_flush = 1'b0;
        funct3 = 3'b000; addr = 32'h0; store_data = 32'h0; pc = 32'h0;
        dmem.ready = 1'b0; dmem.rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", dmem.req, 1'b0);
        check("rst_we", dmem.we, 1'b0);
        check("rst_addr", dmem.addr, 32'h0);
        check("rst_be", dmem.be, 4'h0);
        check("rst_wdata", dmem.wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_stall", lsu_stall, 1'b0);
        check("rst_cause_out", cause_out, 4'h0);
        check("rst_cause_set", cause_set, 1'b0);
        check("rst_mepc_set", mepc_set, 1'b0);
        check("rst_exc_addr", exc_addr, 30'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // SW, ready in the first request cycle
        sb_bus(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h40, 32'h0, 0, 99, 2, 0, 0, 1'b1);
        // SB upper lane
        sb_bus(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5);
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h44, 32'h0, 0, 99, 2, 0, 0, 1'b1);
        // SH upper half
        sb_bus(1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF);
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h48, 32'h0, 0, 99, 2, 0, 0, 1'b1);
        // read+write together behaves as a store
        sb_bus(1'b1, 32'h204, 4'hF, 32'h01020304);
        issue(1'b1, 1'b1, 3'b010, 32'h204, 32'h01020304, 32'h4C, 32'h0, 1, 99, 3, 0, 0, 1'b1);
        // LB / LBU lane 3
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'hFFFFFF80);
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h50, 32'h80000000, 0, 99, 2, 1, 0, 1'b1);
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'h00000080);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h54, 32'h80000000, 0, 99, 2, 1, 0, 1'b1);
        // LB lane 1 positive
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'h0000007F);
        issue(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h58, 32'h00007F00, 0, 99, 2, 1, 0, 1'b1);
        // LH / LHU upper half, LH lower half
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'hFFFF8001);
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h5C, 32'h80010000, 0, 99, 2, 1, 0, 1'b1);
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'h00008001);
        issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h60, 32'h80010000, 0, 99, 2, 1, 0, 1'b1);
        sb_bus(1'b0, 32'h100, 4'h0, 32'h0); sb_load(32'hFFFFFFFE);
        issue(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h64, 32'h0000FFFE, 0, 99, 2, 1, 0, 1'b1);
        // misaligned and illegal ops: no bus traffic, one trap pulse
        sb_trap(4'd4, 30'h10);
        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h40, 32'h0, 0, 99, 1, 0, 1, 1'b0);
        sb_trap(4'd6, 30'h11);
        issue(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h44, 32'h0, 0, 99, 1, 0, 1, 1'b0);
        sb_trap(4'd2, 30'h12);
        issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h48, 32'h0, 0, 99, 1, 0, 1, 1'b0);
        sb_trap(4'd2, 30'h13);
        issue(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h4C, 32'h0, 0, 99, 1, 0, 1, 1'b0);
        // ready withheld for the full budget: access faults
        sb_trap(4'd5, 30'h20);
        issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h80, 32'h0, TB_TIMEOUT, 99, TB_TIMEOUT + 1, 0, 1, 1'b1);
        sb_trap(4'd7, 30'h21);
        issue(1'b0, 1'b1, 3'b010, 32'h108, 32'h0, 32'h84, 32'h0, TB_TIMEOUT, 99, TB_TIMEOUT + 1, 0, 1, 1'b1);
        // ready arrives in the last allowed cycle: normal completion
        sb_bus(1'b0, 32'h108, 4'h0, 32'h0); sb_load(32'hCAFEF00D);
        issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h88, 32'hCAFEF00D, TB_TIMEOUT - 1, 99, TB_TIMEOUT + 1, 1, 0, 1'b1);
        // ready delayed: op at N, ready at N+5
        sb_bus(1'b0, 32'h10C, 4'h0, 32'h0); sb_load(32'h12345678);
        issue(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h8C, 32'h12345678, 4, 99, 6, 1, 0, 1'b1);
        // flush while busy: transfer completes, nothing reported
        sb_bus(1'b0, 32'h110, 4'h0, 32'h0);
        issue(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 32'h90, 32'h55555555, 2, 2, 4, 0, 0, 1'b1);
        // flush with the op presented in IDLE: ignored
        issue(1'b1, 1'b0, 3'b010, 32'h114, 32'h0, 32'h94, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("flush_idle_req", dmem.req, 1'b0);
        @(posedge clk); #1;

        // reset while BUSY abandons the request
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200; pc = 32'hA0;
        @(negedge clk);
        check("rst_mid_pre_stall", lsu_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_busy_req", dmem.req, 1'b1);
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_req_drop", dmem.req, 1'b0);
        check("rst_mid_stall", lsu_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // unit still usable from IDLE afterwards
        sb_bus(1'b0, 32'h200, 4'h0, 32'h0); sb_load(32'h0BADF00D);
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hA4, 32'h0BADF00D, 0, 99, 2, 1, 0, 1'b1);

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
